// File: rtl/mem_responder_if.sv
// Request/response bus between a controller (master) and the memory responder (slave).
interface mem_responder_if;
  logic        REQ;
  logic        WR;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic [31:0] RDATA;
  logic        ACK;
  logic        ERR;
  logic        BUSY;

  modport master (output REQ, WR, ADDR, WDATA, input RDATA, ACK, ERR, BUSY);
  modport slave  (input REQ, WR, ADDR, WDATA, output RDATA, ACK, ERR, BUSY);
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory that answers one request at a time after a fixed wait,
// flagging misaligned or out-of-range addresses with ERR instead of touching storage.
module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic            CLK,
  input  logic            RST,
  mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic          addr_bad;
  logic          respond;
  logic          mem_we;

  assign idx      = addr_q[AW+1:2];
  assign addr_bad = (addr_q[1:0] != 2'b00) || ((addr_q >> (AW + 2)) != 32'd0);
  assign respond  = (state_q == WAIT) && (cnt_q == 3'd0);
  assign mem_we   = respond && wr_q && !addr_bad;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.REQ) begin
          state_d = WAIT;
          cnt_d   = 3'(LATENCY - 1);
          wr_d    = bus.WR;
          addr_d  = bus.ADDR;
          wdata_d = bus.WDATA;
        end
      end
      WAIT: begin
        if (respond) begin
          state_d = RESP;
          ack_d   = 1'b1;
          err_d   = addr_bad;
          // A write echoes its own data so a caller never sees the pre-write word.
          if (addr_bad)  rdata_d = 32'd0;
          else if (wr_q) rdata_d = wdata_q;
          else           rdata_d = mem_q[idx];
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // NOTE: storage is cleared by reset, so it is built from resettable flops, not a RAM macro.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign bus.RDATA = rdata_q;
  assign bus.ACK   = ack_q;
  assign bus.ERR   = err_q;
  assign bus.BUSY  = (state_q != IDLE);
endmodule
